// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the backing-memory controller.
// Provides the FSM state encoding, the posted-write queue entry layout and
// the word-address to line-base helper used for read-after-write ordering.
package data_mem_pkg;

  localparam int LINE_BITS      = 512;
  localparam int WORDS_PER_LINE = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RETIRE,
    ST_DELIVER
  } state_t;

  typedef struct packed {
    logic [31:0] word_addr;
    logic [31:0] data;
  } wq_entry_t;

  // Line base of a word index: the 16 words of a line share all but the low 4 bits.
  function automatic logic [31:0] line_of(input logic [31:0] word_addr);
    return {word_addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/data_mem_wq.sv
// Posted write queue: circular FIFO of {word address, data} with full/empty/count.
// Ports: push/pop handshake, head entry, registered full flag, occupancy count,
// and a combinational match flag set when any valid entry falls in i_match_line.
module data_mem_wq
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wq_entry_t              i_push_dat,
  input  logic                   i_pop,
  output wq_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  input  logic [31:0]            i_match_line,
  output logic                   o_match
);

  localparam int PW = $clog2(DEPTH);

  wq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [PW:0]   w_count_nxt;
  logic          r_full;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_off;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_count != '0);

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    o_match = 1'b0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if (({1'b0, w_off} < r_count) && (line_of(r_mem[i].word_addr) == i_match_line))
        o_match = 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/data_mem_ctrl.sv
// Backing-memory controller: 16-word line fills plus a posted write-through store queue.
// Ports: rd_req/rd_addr -> rd_valid/rd_data (line); wr_pulse/wr_addr/wr_data -> wr_ack,
// wr_done per committed store, wq_full; busy while the FSM is not IDLE.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_WORDS  = 65536,
  parameter int RD_LATENCY = 8,
  parameter int WR_LATENCY = 4,
  parameter int WQ_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rd_req,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic                 o_rd_valid,
  output logic [LINE_BITS-1:0] o_rd_data,
  input  logic                 i_wr_pulse,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [31:0]          i_wr_data,
  output logic                 o_wr_ack,
  output logic                 o_wr_done,
  output logic                 o_wq_full,
  output logic                 o_busy
);

  localparam int AW      = $clog2(MEM_WORDS);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [31:0]          r_mem [MEM_WORDS];
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [AW-1:0]        r_line_base;
  logic                 r_rd_valid;
  logic [LINE_BITS-1:0] r_rd_data;
  logic                 r_wr_done;
  logic                 r_busy;

  wq_entry_t            w_wr_entry;
  wq_entry_t            w_head;
  logic                 w_wq_full;
  logic                 w_wq_empty;
  logic [$clog2(WQ_DEPTH):0] w_wq_count;
  logic                 w_rd_conflict;
  logic [31:0]          w_rd_line;
  logic                 w_commit;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_unused;

  // Upper address bits alias onto the storage; only the word index is kept.
  assign w_wr_entry.word_addr = 32'(i_wr_addr[AW+1:2]);
  assign w_wr_entry.data      = i_wr_data;
  assign w_rd_line            = line_of(32'(i_rd_addr[AW+1:2]));

  assign w_commit = (r_state == ST_RETIRE) && (r_cnt == '0);

  data_mem_wq #(.DEPTH(WQ_DEPTH)) u_wq (
    .clk          (clk),
    .rst          (rst),
    .i_push       (i_wr_pulse),
    .i_push_dat   (w_wr_entry),
    .i_pop        (w_commit),
    .o_head       (w_head),
    .o_full       (w_wq_full),
    .o_empty      (w_wq_empty),
    .o_count      (w_wq_count),
    .i_match_line (w_rd_line),
    .o_match      (w_rd_conflict)
  );

  // Storage is never reset; an async reset mid-retire leaves RETIRE before the commit edge.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_head.word_addr[AW-1:0]] <= w_head.data;
  end

  always_comb begin
    w_line = '0;
    for (int k = 0; k < WORDS_PER_LINE; k++)
      w_line[32*k +: 32] = r_mem[{r_line_base[AW-1:4], 4'(k)}];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_line_base <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wr_done   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Reads win unless a queued store hits the same line; then drain first.
          if (i_rd_req && !w_rd_conflict) begin
            r_line_base <= w_rd_line[AW-1:0];
            r_cnt       <= CNT_W'(RD_LATENCY - 1);
            r_state     <= ST_FILL;
            r_busy      <= 1'b1;
          end else if (!w_wq_empty) begin
            r_cnt   <= CNT_W'(WR_LATENCY - 1);
            r_state <= ST_RETIRE;
            r_busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (r_cnt == '0) begin
            r_rd_data  <= w_line;
            r_rd_valid <= 1'b1;
            r_state    <= ST_DELIVER;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RETIRE: begin
          if (r_cnt == '0) begin
            r_wr_done <= 1'b1;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DELIVER: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_wr_ack   = i_wr_pulse && !w_wq_full;
  assign o_wr_done  = r_wr_done;
  assign o_wq_full  = w_wq_full;
  assign o_busy     = r_busy;

  // Address bits outside the word index, the spare head-address bits and the count are unused.
  assign w_unused = ^{i_rd_addr, i_wr_addr, w_head, w_wq_count};

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [31:0]  rd_addr = '0;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic         wr_pulse = 1'b0;
  logic [31:0]  wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         wr_ack;
  logic         wr_done;
  logic         wq_full;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  data_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .i_wr_pulse (wr_pulse),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_wr_ack   (wr_ack),
    .o_wr_done  (wr_done),
    .o_wq_full  (wq_full),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle store once the queue has room.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    int g;
    g = 0;
    while (wq_full && g < 100) begin
      cyc();
      g++;
    end
    wr_pulse = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    n_vec++;
    if (wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL store_ack addr=%h got=%b want=1", a, wr_ack);
    end
    cyc();
    wr_pulse = 1'b0;
  endtask

  // Wait until the controller has been idle two cycles in a row (queue drained).
  task automatic drain();
    int idle;
    int g;
    idle = 0;
    g = 0;
    while (idle < 2 && g < 500) begin
      cyc();
      if (!busy) idle++;
      else idle = 0;
      g++;
    end
    n_vec++;
    if (idle < 2) begin
      n_err++;
      $display("FAIL drain_timeout busy=%b", busy);
    end
  endtask

  // Fill request; lat counts cycles from request to rd_valid (100 = timeout).
  task automatic do_read(input logic [31:0] a, output int lat, output logic [511:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!rd_valid && lat < 100);
    rd_req = 1'b0;
    d = rd_data;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rd_valid, wr_done, wq_full, busy, wr_ack} !== 5'b0 || rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b d=%h wd=%b f=%b b=%b a=%b want all 0",
               rd_valid, rd_data[31:0], wr_done, wq_full, busy, wr_ack);
    end
    rst = 1'b0;
    cyc();
    cyc();
    n_vec++;
    if ({rd_valid, wr_done, wq_full, busy} !== 4'b0) begin
      n_err++;
      $display("FAIL post_reset_idle got v=%b wd=%b f=%b b=%b want 0", rd_valid, wr_done, wq_full, busy);
    end
  endtask

  task automatic test_line_fill();
    logic [511:0] exp;
    logic [511:0] d;
    int lat;
    for (int k = 0; k < 16; k++) begin
      store(32'h40 + 32'(4 * k), 32'hA000_0010 + 32'(k));
      exp[32*k +: 32] = 32'hA000_0010 + 32'(k);
    end
    drain();
    do_read(32'h0000_0040, lat, d);
    n_vec++;
    if (lat !== 9) begin
      n_err++;
      $display("FAIL fill_latency got=%0d want=9", lat);
    end
    n_vec++;
    if (d[31:0] !== 32'hA000_0010 || d[511:480] !== 32'hA000_001F) begin
      n_err++;
      $display("FAIL fill_ends got w0=%h w15=%h want A0000010 A000001F", d[31:0], d[511:480]);
    end
    n_vec++;
    if (d !== exp) begin
      n_err++;
      $display("FAIL fill_line got=%h want=%h", d, exp);
    end
    cyc();
    n_vec++;
    if (rd_valid !== 1'b0 || rd_data !== exp) begin
      n_err++;
      $display("FAIL fill_pulse_hold got v=%b w0=%h want v=0 w0=%h", rd_valid, rd_data[31:0], exp[31:0]);
    end
    cyc();
  endtask

  task automatic test_queue_full();
    int t;
    int times[$];
    logic [511:0] d;
    int lat;
    store(32'h110, 32'h5555_0110);
    drain();
    t = 0;
    for (int k = 0; k < 4; k++) begin
      wr_pulse = 1'b1;
      wr_addr  = 32'h100 + 32'(4 * k);
      wr_data  = 32'hC000_0000 + 32'(k);
      #1;
      n_vec++;
      if (wr_ack !== 1'b1) begin
        n_err++;
        $display("FAIL qfull_ack%0d got=%b want=1", k, wr_ack);
      end
      cyc();
      t++;
    end
    wr_pulse = 1'b1;
    wr_addr  = 32'h110;
    wr_data  = 32'hFFFF_FFFF;
    #1;
    n_vec++;
    if (wq_full !== 1'b1 || wr_ack !== 1'b0) begin
      n_err++;
      $display("FAIL qfull_drop got full=%b ack=%b want full=1 ack=0", wq_full, wr_ack);
    end
    cyc();
    t++;
    wr_pulse = 1'b0;
    while (t < 30) begin
      if (wr_done) times.push_back(t);
      cyc();
      t++;
    end
    n_vec++;
    if (times.size() != 4) begin
      n_err++;
      $display("FAIL qfull_done_count got=%0d want=4", times.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (times[k] != 6 + 5 * k) begin
          n_err++;
          $display("FAIL qfull_done_time%0d got=%0d want=%0d", k, times[k], 6 + 5 * k);
        end
      end
    end
    drain();
    do_read(32'h100, lat, d);
    n_vec++;
    if (lat !== 9 || d[127:0] !== {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000}) begin
      n_err++;
      $display("FAIL qfull_data got lat=%0d w=%h want lat=9 w=C0000003C0000002C0000001C0000000", lat, d[127:0]);
    end
    n_vec++;
    if (d[159:128] !== 32'h5555_0110) begin
      n_err++;
      $display("FAIL qfull_dropped_store got=%h want=55550110", d[159:128]);
    end
    cyc();
  endtask

  task automatic test_raw_conflict();
    logic [511:0] d;
    int lat;
    store(32'h204, 32'hDEAD_BEEF);
    do_read(32'h200, lat, d);
    n_vec++;
    if (lat !== 14) begin
      n_err++;
      $display("FAIL raw_latency got=%0d want=14", lat);
    end
    n_vec++;
    if (d[63:32] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL raw_data got=%h want=DEADBEEF", d[63:32]);
    end
    cyc();
    drain();
  endtask

  task automatic test_read_priority();
    int t;
    int rv;
    int wd;
    logic [511:0] d;
    int lat;
    store(32'h400, 32'h1234_5678);
    rd_req  = 1'b1;
    rd_addr = 32'h800;
    t = 0;
    rv = -1;
    wd = -1;
    while (t < 40) begin
      cyc();
      t++;
      if (rd_valid && rv < 0) begin
        rv = t;
        rd_req = 1'b0;
      end
      if (wr_done && wd < 0) wd = t;
    end
    rd_req = 1'b0;
    n_vec++;
    if (rv != 9) begin
      n_err++;
      $display("FAIL prio_read_time got=%0d want=9", rv);
    end
    n_vec++;
    if (wd != 15) begin
      n_err++;
      $display("FAIL prio_done_time got=%0d want=15", wd);
    end
    drain();
    do_read(32'h400, lat, d);
    n_vec++;
    if (lat !== 9 || d[31:0] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL prio_store_data got lat=%0d w0=%h want lat=9 w0=12345678", lat, d[31:0]);
    end
    cyc();
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [511:0] d;
    int lat;
    rd_req  = 1'b1;
    rd_addr = 32'h40;
    repeat (4) cyc();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({rd_valid, wr_done, wq_full, busy} !== 4'b0 || rd_data !== '0) begin
      n_err++;
      $display("FAIL rst_fill_outputs got v=%b wd=%b f=%b b=%b w0=%h want 0",
               rd_valid, wr_done, wq_full, busy, rd_data[31:0]);
    end
    rd_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      cyc();
      if (rd_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_fill_no_valid got=%0d pulses want=0", seen);
    end
    store(32'h40, 32'hBAD0_0000);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({wr_done, wq_full, busy} !== 3'b0) begin
      n_err++;
      $display("FAIL rst_retire_outputs got wd=%b f=%b b=%b want 0", wr_done, wq_full, busy);
    end
    cyc();
    cyc();
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      cyc();
      if (wr_done) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_retire_no_done got=%0d pulses want=0", seen);
    end
    do_read(32'h40, lat, d);
    n_vec++;
    if (lat !== 9 || d[31:0] !== 32'hA000_0010) begin
      n_err++;
      $display("FAIL rst_recover got lat=%0d w0=%h want lat=9 w0=A0000010", lat, d[31:0]);
    end
    cyc();
  endtask

  task automatic test_wrap_enq_deq();
    logic [511:0] d;
    int lat;
    for (int k = 0; k < 3; k++) begin
      wr_pulse = 1'b1;
      wr_addr  = 32'h600 + 32'(4 * k);
      wr_data  = 32'hE000_0000 + 32'(k);
      cyc();
    end
    wr_pulse = 1'b0;
    cyc();
    cyc();
    wr_pulse = 1'b1;
    wr_addr  = 32'h60C;
    wr_data  = 32'hE000_0003;
    #1;
    n_vec++;
    if (wr_ack !== 1'b1 || wq_full !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_enq_ack got ack=%b full=%b want ack=1 full=0", wr_ack, wq_full);
    end
    cyc();
    wr_addr = 32'h610;
    wr_data = 32'hE000_0004;
    #1;
    n_vec++;
    if (wr_done !== 1'b1 || wq_full !== 1'b0 || wr_ack !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_same_cycle got done=%b full=%b ack=%b want 1 0 1", wr_done, wq_full, wr_ack);
    end
    cyc();
    wr_pulse = 1'b0;
    n_vec++;
    if (wq_full !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_count_full got=%b want=1", wq_full);
    end
    drain();
    do_read(32'h600, lat, d);
    n_vec++;
    if (lat !== 9 || d[159:0] !== {32'hE000_0004, 32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000}) begin
      n_err++;
      $display("FAIL wrap_data got lat=%0d w=%h want lat=9 w=E0000004E0000003E0000002E0000001E0000000",
               lat, d[159:0]);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_line_fill();
    test_queue_full();
    test_raw_conflict();
    test_read_priority();
    test_reset_abort();
    test_wrap_enq_deq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Backing-memory controller directly downstream of the data cache.
- Serves 512-bit (16-word) line fills on cache read misses.
- Absorbs write-through word stores in a small posted write queue and retires them to a word-addressed storage array with modelled latencies.
- Enforces read-after-write ordering between queued stores and line fills.

Parameters:
- ADDR_W, 32, byte address width.
- MEM_WORDS, 65536, storage depth in 32-bit words; must be a power of two and a multiple of 16.
- RD_LATENCY, 8, cycles from fill start to line delivery; minimum 1.
- WR_LATENCY, 4, cycles to retire one queued store; minimum 1.
- WQ_DEPTH, 4, write queue entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rd_req  in  1  level; cache requests a fill of the line at rd_addr.
- rd_addr  in  ADDR_W  byte address of the miss; bits [5:0] are ignored.
- rd_valid  out  1  one-cycle pulse; rd_data holds the requested line.
- rd_data  out  512  line data; word k sits at bits [32k+31:32k].
- wr_pulse  in  1  one-cycle store request.
- wr_addr  in  ADDR_W  byte address of the store; bits [1:0] are ignored.
- wr_data  in  32  store data.
- wr_ack  out  1  same-cycle combinational accept, equal to wr_pulse AND NOT wq_full.
- wr_done  out  1  one-cycle pulse when the oldest store commits to storage.
- wq_full  out  1  write queue full.
- busy  out  1  controller FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: rd_valid=0, rd_data=0, wr_done=0, wq_full=0, busy=0.
  - Queue pointers and count cleared; FSM to IDLE; latency counter cleared.
  - Storage contents are not cleared.
  - Reset in mid-fill or mid-retire aborts the operation: no rd_valid, no wr_done, the partial store is not written.
- Write queue:
  - Circular FIFO of {word address, data}.
  - Enqueue on wr_pulse && !wq_full.
  - A wr_pulse while full is dropped, with wr_ack=0; the cache must retry.
  - Pointers wrap modulo WQ_DEPTH; count is held at log2(WQ_DEPTH)+1 bits.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - wq_full is registered from the next-state count.
- Address mapping:
  - Word index = addr[log2(MEM_WORDS)+1:2]; higher bits alias.
  - Line base = word index with the low 4 bits cleared.
- FSM states: IDLE, FILL, RETIRE, DELIVER.
- IDLE:
  - If rd_req and no queued entry has the same line address as rd_addr: latch the line address, load the counter with RD_LATENCY-1, go to FILL. Reads have priority.
  - Otherwise, if the queue is non-empty: load the counter with WR_LATENCY-1, go to RETIRE. This includes a read that conflicts with a queued store, which forces draining until there is no conflict.
- RETIRE:
  - Count down.
  - At 0: write the head entry to storage, pop it, pulse wr_done for one cycle, return to IDLE.
- FILL:
  - Count down.
  - At 0: assemble the 16 words from the latched line base into rd_data, go to DELIVER.
  - Stores may still be enqueued during FILL. Stores to the line being filled do not modify the fill.
  - The cache orders such a store only against a subsequent request.
- DELIVER:
  - rd_valid=1 for exactly one cycle.
  - rd_data then holds its value until the next fill completes.
  - Return to IDLE.
  - A new fill cannot start before the cycle after DELIVER.
- Fill latency:
  - Minimum rd_req to rd_valid is RD_LATENCY+1 cycles without conflicts.
  - A conflicting read adds (WR_LATENCY+1) cycles per queued entry ahead of and including the last matching store.
- A rd_addr change while in FILL is ignored; the latched line is delivered.
- rd_req held after rd_valid restarts a fill the next cycle. The cache deasserts rd_req on rd_valid.

Decomposition:
- Package data_mem_pkg:
  - LINE_BITS=512, WORDS_PER_LINE=16.
  - FSM state enum.
  - wq_entry_t struct {word_addr, data}.
  - Function line_of(addr).
- Sub-module data_mem_wq: parameterised FIFO with full/empty/count.
  - Also provides a combinational line-match output over all valid entries for a given line address.

Test Plan:
- Preload storage with word i = 32'hA000_0000+i. rd_req with rd_addr=32'h0000_0040 -> rd_valid after 9 cycles; rd_data[31:0]=A000_0010, rd_data[511:480]=A000_001F.
- Four wr_pulse cycles to addresses 0x100, 0x104, 0x108, 0x10C -> wr_ack=1 on all four, wq_full=1. A fifth wr_pulse -> wr_ack=0 and the store is dropped. Then four wr_done pulses spaced 5 cycles apart.
- Store 32'hDEAD_BEEF to 0x204, then rd_req for 0x200 in the next cycle -> retire happens first. rd_valid arrives 5+9 cycles after the retire starts, with rd_data[63:32]=DEAD_BEEF.
- Store to 0x400 queued; rd_req for 0x800 -> read served first (rd_valid at cycle 9), then the store retires with wr_done.
- Assert rst during FILL cycle 4 -> no rd_valid; all outputs 0 in the same cycle; a subsequent request completes normally.
- Enqueue and dequeue in the same cycle with count=WQ_DEPTH-1 -> count unchanged, wq_full stays 0, pointer wrap is correct.
